snax_hwpe_tcdm_rsp_buffer: RTL and testbench
============================================

// Module: snax_hwpe_tcdm_rsp_buffer
// PURPOSE
//  Per-port bridge between one HWPE streamer TCDM port (req/gnt, r_valid) of the MAC engine and one
//  SNAX valid-ready TCDM port (tcdm_req_t/tcdm_rsp_t) into local memory. It tracks outstanding
//  requests in order, buffers read data so a stalling streamer (hwpe_r_ready_i) never loses a
//  response, and discards write responses. One instance per SnaxTcdmPorts lane.
// PARAMETERS
//  DataWidth   32      TCDM data width; byte-enable width is DataWidth/8
//  AddrWidth   32      TCDM address width
//  Depth       4       max in-flight requests plus buffered reads (power of 2, >=2)
//  tcdm_req_t  logic   SNAX TCDM request type (q.addr/write/data/strb, q_valid)
//  tcdm_rsp_t  logic   SNAX TCDM response type (q_ready, p.data, p_valid)
// PORTS
//  clk_i           in   1              clock
//  rst_i           in   1              reset, synchronous, active-high
//  hwpe_req_i      in   1              HWPE request
//  hwpe_gnt_o      out  1              HWPE grant (transfer = req & gnt)
//  hwpe_add_i      in   AddrWidth      byte address
//  hwpe_wen_i      in   1              1 = read, 0 = write (HWPE convention)
//  hwpe_be_i       in   DataWidth/8    byte enables
//  hwpe_data_i     in   DataWidth      write data
//  hwpe_r_data_o   out  DataWidth      read data
//  hwpe_r_valid_o  out  1              read data valid
//  hwpe_r_ready_i  in   1              streamer accepts read data
//  tcdm_req_o      out  tcdm_req_t     SNAX TCDM request
//  tcdm_rsp_i      in   tcdm_rsp_t     SNAX TCDM response (no p_ready: must always be sunk)
//  err_o           out  1              sticky: response received with nothing outstanding
// BEHAVIOUR
//  - Reset (rst_i=1 at edge): counters, FIFO pointers, err_o cleared; all outputs 0 next cycle.
//  - Credits: cnt = in-flight + buffered reads (0..Depth). Issue allowed iff cnt < Depth.
//  - Request path combinational: q_valid = hwpe_req_i & (cnt<Depth); hwpe_gnt_o = q_valid & q_ready.
//    q.write = ~hwpe_wen_i; addr/data/strb pass through unchanged.
//  - On grant push 1-bit kind (read/write) into the in-order tag queue (Depth entries); cnt++.
//  - On tcdm p_valid pop tag queue: read -> push p.data into data FIFO (cnt unchanged);
//    write -> drop, cnt--.
//  - hwpe_r_valid_o = data FIFO non-empty; pop on r_valid & r_ready; cnt--.
//  - Read latency, p_valid to hwpe_r_valid_o: 1 cycle. Order of responses = order of grants.
//  - Simultaneous grant + release same cycle: cnt unchanged; grant+write-drop+read-pop: cnt-1.
//  - Full (cnt==Depth): gnt=0 even with q_ready=1; resumes the cycle after any release.
//  - p_valid with empty tag queue: ignored (no push, cnt unchanged), err_o set until reset.
//  - Reset mid-operation flushes everything; late responses to pre-reset requests hit the rule above.
// CONFIGURATION
//  SNAX_TCDM_RSP_BYPASS_EN defined: when data FIFO empty and p_valid of a read, p.data drives
//   hwpe_r_data_o/r_valid_o same cycle; if r_ready_i=1 it is not stored (cnt--), else it is pushed.
//  Undefined: all reads go through the FIFO, fixed 1-cycle latency (timing-safe default).
// STRUCTURE
//  - snax_tcdm_buf_pkg: cnt_t (clog2(Depth+1) bits), ptr_t, kind_e {KIND_WRITE, KIND_READ}.
//  - Sub-module snax_tcdm_rsp_fifo: sync FIFO (Depth x DataWidth, full/empty, push/pop, rst_i);
//    instantiated twice (width 1 for tags, DataWidth for read data). Top holds credit counter.
// TESTING
//  1 Reset: rst_i=1 2 cycles with hwpe_req_i=1 -> gnt_o=0, r_valid_o=0, err_o=0 throughout.
//  2 Read 0x100, memory p_valid 2 cycles later with 0xDEADBEEF, r_ready=1 -> r_data=0xDEADBEEF
//    1 cycle after p_valid (0 cycles with BYPASS_EN), cnt back to 0.
//  3 r_ready=0, issue 6 back-to-back reads, Depth=4 -> exactly 4 grants, 5th stalls; release
//    r_ready -> 4 responses in issue order, remaining 2 granted.
//  4 Interleave W,R,W,R with p_valid each next cycle -> only 2 read responses on HWPE side, in order.
//  5 q_ready=0 for 3 cycles with req=1 -> gnt_o=0, cnt unchanged, no tag pushed.
//  6 Assert rst_i with 3 reads in flight, then deliver 3 p_valid -> no r_valid_o, err_o=1 after first.

Source files
------------

// File: rtl/snax_tcdm_buf_pkg.sv
// Shared types for the HWPE-to-SNAX TCDM response buffer: credit/pointer widths,
// response kind tags and default SNAX TCDM request/response structures.
package snax_tcdm_buf_pkg;

    localparam int unsigned DefaultDataWidth = 32;
    localparam int unsigned DefaultAddrWidth = 32;
    localparam int unsigned DefaultDepth     = 4;

    typedef logic [$clog2(DefaultDepth + 1)-1:0] cnt_t;
    typedef logic [$clog2(DefaultDepth)-1:0]     ptr_t;

    typedef enum logic {
        KIND_WRITE = 1'b0,
        KIND_READ  = 1'b1
    } kind_e;

    typedef struct packed {
        logic [DefaultAddrWidth-1:0]   addr;
        logic                          write;
        logic [DefaultDataWidth-1:0]   data;
        logic [DefaultDataWidth/8-1:0] strb;
    } tcdm_req_chan_t;

    typedef struct packed {
        tcdm_req_chan_t q;
        logic           q_valid;
    } tcdm_req_default_t;

    typedef struct packed {
        logic [DefaultDataWidth-1:0] data;
    } tcdm_rsp_chan_t;

    typedef struct packed {
        logic           q_ready;
        tcdm_rsp_chan_t p;
        logic           p_valid;
    } tcdm_rsp_default_t;

endpackage

// File: rtl/snax_tcdm_rsp_fifo.sv
// Synchronous FIFO with synchronous active-high reset, used for the in-order
// request tag queue and for buffering read responses.
module snax_tcdm_rsp_fifo #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrWidth = $clog2(Depth);
    localparam int unsigned CntWidth = $clog2(Depth + 1);

    logic [Width-1:0]    mem_q [Depth];
    logic [PtrWidth-1:0] wr_ptr_q;
    logic [PtrWidth-1:0] rd_ptr_q;
    logic [CntWidth-1:0] count_q;
    logic                do_push;
    logic                do_pop;

    assign full_o  = (count_q == CntWidth'(Depth));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    // Storage is left unreset; the occupancy counter alone defines valid entries.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PtrWidth'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CntWidth'(1);
                2'b01:   count_q <= count_q - CntWidth'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/snax_hwpe_tcdm_rsp_buffer.sv
// Bridges one HWPE streamer TCDM port to one SNAX valid-ready TCDM port with credit-limited
// in-order tracking and read buffering. Optional same-cycle read bypass: SNAX_TCDM_RSP_BYPASS_EN.
module snax_hwpe_tcdm_rsp_buffer
    import snax_tcdm_buf_pkg::*;
#(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned Depth     = 4,
    parameter type tcdm_req_t = tcdm_req_default_t,
    parameter type tcdm_rsp_t = tcdm_rsp_default_t
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   hwpe_req_i,
    output logic                   hwpe_gnt_o,
    input  logic [AddrWidth-1:0]   hwpe_add_i,
    input  logic                   hwpe_wen_i,
    input  logic [DataWidth/8-1:0] hwpe_be_i,
    input  logic [DataWidth-1:0]   hwpe_data_i,
    output logic [DataWidth-1:0]   hwpe_r_data_o,
    output logic                   hwpe_r_valid_o,
    input  logic                   hwpe_r_ready_i,
    output tcdm_req_t              tcdm_req_o,
    input  tcdm_rsp_t              tcdm_rsp_i,
    output logic                   err_o
);

    localparam int unsigned CntWidth = $clog2(Depth + 1);

    logic [CntWidth-1:0]  cnt_q;
    logic [CntWidth-1:0]  cnt_d;
    logic                 err_q;
    logic                 can_issue;
    logic                 q_valid;
    logic                 grant;
    logic [0:0]           tag_wdata;
    logic [0:0]           tag_rdata;
    logic                 tag_full;
    logic                 tag_empty;
    kind_e                rsp_kind;
    logic                 rsp_valid;
    logic                 rsp_is_read;
    logic                 rsp_is_write;
    logic                 bypass;
    logic                 data_push;
    logic                 data_pop;
    logic                 data_full;
    logic                 data_empty;
    logic [DataWidth-1:0] fifo_rdata;
    logic                 read_release;

    // Reset also blocks new grants so nothing is issued while state is being flushed.
    assign can_issue  = (cnt_q < CntWidth'(Depth)) & ~tag_full;
    assign q_valid    = hwpe_req_i & ~rst_i & can_issue;
    assign grant      = q_valid & tcdm_rsp_i.q_ready;
    assign hwpe_gnt_o = grant;

    always_comb begin
        tcdm_req_o         = '0;
        tcdm_req_o.q_valid = q_valid;
        tcdm_req_o.q.addr  = hwpe_add_i;
        tcdm_req_o.q.write = ~hwpe_wen_i;
        tcdm_req_o.q.data  = hwpe_data_i;
        tcdm_req_o.q.strb  = hwpe_be_i;
    end

    assign tag_wdata = hwpe_wen_i ? KIND_READ : KIND_WRITE;
    assign rsp_kind  = kind_e'(tag_rdata);

    snax_tcdm_rsp_fifo #(
        .Width (1),
        .Depth (Depth)
    ) i_tag_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (grant),
        .wdata_i (tag_wdata),
        .pop_i   (rsp_valid),
        .rdata_o (tag_rdata),
        .full_o  (tag_full),
        .empty_o (tag_empty)
    );

    // A response with no outstanding tag is dropped here and only flagged via err_o.
    assign rsp_valid    = tcdm_rsp_i.p_valid & ~tag_empty;
    assign rsp_is_read  = rsp_valid & (rsp_kind == KIND_READ);
    assign rsp_is_write = rsp_valid & (rsp_kind == KIND_WRITE);

`ifdef SNAX_TCDM_RSP_BYPASS_EN
    assign bypass = rsp_is_read & data_empty & ~rst_i;
`else
    assign bypass = 1'b0;
`endif

    assign hwpe_r_valid_o = ~data_empty | bypass;
    assign hwpe_r_data_o  = ~data_empty ? fifo_rdata :
                            (bypass ? tcdm_rsp_i.p.data : '0);
    assign read_release   = hwpe_r_valid_o & hwpe_r_ready_i;
    assign data_pop       = ~data_empty & hwpe_r_ready_i;
    assign data_push      = rsp_is_read & ~data_full & ~(bypass & hwpe_r_ready_i);

    snax_tcdm_rsp_fifo #(
        .Width (DataWidth),
        .Depth (Depth)
    ) i_data_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (data_push),
        .wdata_i (tcdm_rsp_i.p.data),
        .pop_i   (data_pop),
        .rdata_o (fifo_rdata),
        .full_o  (data_full),
        .empty_o (data_empty)
    );

    // Credits cover both in-flight requests and reads parked in the data FIFO.
    always_comb begin
        cnt_d = cnt_q;
        if (grant) begin
            cnt_d = cnt_d + CntWidth'(1);
        end
        if (rsp_is_write) begin
            cnt_d = cnt_d - CntWidth'(1);
        end
        if (read_release) begin
            cnt_d = cnt_d - CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (tcdm_rsp_i.p_valid & tag_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_snax_hwpe_tcdm_rsp_buffer.sv
// Self-checking bench for snax_hwpe_tcdm_rsp_buffer: directed scenarios plus randomized traffic
// against a queue-based model; follows SNAX_TCDM_RSP_BYPASS_EN when defined.
module tb_snax_hwpe_tcdm_rsp_buffer;
    import snax_tcdm_buf_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b1;
    logic        wen = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = '0;
    logic        q_ready = 1'b1;
    logic        p_valid = 1'b0;
    logic [31:0] p_data = '0;
    logic        r_ready = 1'b0;

    logic              gnt;
    logic [31:0]       r_data;
    logic              r_valid;
    logic              err;
    tcdm_req_default_t tcdm_req;
    tcdm_rsp_default_t tcdm_rsp;

    int checks = 0;
    int errors = 0;

    // Behavioural model: kinds of granted-but-unanswered requests, buffered read data,
    // sticky error flag, and the memory's own queue of responses it still owes.
    bit          inflight[$];
    logic [31:0] rbuf[$];
    logic [31:0] pending[$];
    bit          model_err = 1'b0;

    always #5 clk = ~clk;

    always_comb begin
        tcdm_rsp.q_ready = q_ready;
        tcdm_rsp.p.data  = p_data;
        tcdm_rsp.p_valid = p_valid;
    end

    snax_hwpe_tcdm_rsp_buffer #(
        .DataWidth  (32),
        .AddrWidth  (32),
        .Depth      (DEPTH),
        .tcdm_req_t (tcdm_req_default_t),
        .tcdm_rsp_t (tcdm_rsp_default_t)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .hwpe_req_i     (req),
        .hwpe_gnt_o     (gnt),
        .hwpe_add_i     (addr),
        .hwpe_wen_i     (wen),
        .hwpe_be_i      (be),
        .hwpe_data_i    (wdata),
        .hwpe_r_data_o  (r_data),
        .hwpe_r_valid_o (r_valid),
        .hwpe_r_ready_i (r_ready),
        .tcdm_req_o     (tcdm_req),
        .tcdm_rsp_i     (tcdm_rsp),
        .err_o          (err)
    );

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge, then return at the falling edge.
    task automatic applyStimulus(input logic i_rst, input logic i_req, input logic i_wen,
                                 input logic [31:0] i_addr, input logic i_q_ready,
                                 input logic i_p_valid, input logic [31:0] i_p_data,
                                 input logic i_r_ready);
        @(posedge clk);
        #1;
        rst     = i_rst;
        req     = i_req;
        wen     = i_wen;
        addr    = i_addr;
        q_ready = i_q_ready;
        p_valid = i_p_valid;
        p_data  = i_p_data;
        r_ready = i_r_ready;
        wdata   = $urandom;
        be      = 4'($urandom);
        @(negedge clk);
    endtask

    // Compare DUT against the model for this cycle, then advance the model past the next edge.
    task automatic checkOutput();
        int          cnt;
        bit          exp_qvalid;
        bit          exp_gnt;
        bit          exp_rvalid;
        bit          byp;
        bit          kind;
        logic [31:0] exp_rdata;

        cnt        = inflight.size() + rbuf.size();
        exp_qvalid = req && !rst && (cnt < DEPTH);
        exp_gnt    = exp_qvalid && q_ready;
        byp        = 1'b0;
`ifdef SNAX_TCDM_RSP_BYPASS_EN
        byp = !rst && p_valid && (rbuf.size() == 0) && (inflight.size() > 0) && inflight[0];
`endif
        exp_rvalid = (rbuf.size() > 0) || byp;
        exp_rdata  = (rbuf.size() > 0) ? rbuf[0] : p_data;

        checkValue("gnt", {31'b0, gnt}, {31'b0, exp_gnt});
        checkValue("q_valid", {31'b0, tcdm_req.q_valid}, {31'b0, exp_qvalid});
        if (exp_qvalid) begin
            checkValue("q_addr", tcdm_req.q.addr, addr);
            checkValue("q_write", {31'b0, tcdm_req.q.write}, {31'b0, !wen});
            checkValue("q_data", tcdm_req.q.data, wdata);
            checkValue("q_strb", {28'b0, tcdm_req.q.strb}, {28'b0, be});
        end
        checkValue("r_valid", {31'b0, r_valid}, {31'b0, exp_rvalid});
        if (exp_rvalid) begin
            checkValue("r_data", r_data, exp_rdata);
        end
        checkValue("err", {31'b0, err}, {31'b0, model_err});

        if (rst) begin
            inflight.delete();
            rbuf.delete();
            model_err = 1'b0;
        end else begin
            if (exp_rvalid && r_ready && (rbuf.size() > 0)) begin
                void'(rbuf.pop_front());
            end
            if (p_valid) begin
                if (inflight.size() == 0) begin
                    model_err = 1'b1;
                end else begin
                    kind = inflight.pop_front();
                    if (kind && !(byp && r_ready)) begin
                        rbuf.push_back(p_data);
                    end
                end
            end
            if (exp_gnt) begin
                inflight.push_back(wen);
            end
        end

        if (p_valid && (pending.size() > 0)) begin
            void'(pending.pop_front());
        end
        if (exp_gnt) begin
            pending.push_back($urandom);
        end
    endtask

    always @(negedge clk) begin
        checkOutput();
    end

    initial begin
        int          grants;
        int          got;
        logic [31:0] seen[$];
        logic        pv;
        logic [31:0] pd;

        // Reset held with a pending request: nothing may be granted or reported.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 32'h40, 1'b1, 1'b0, 32'h0, 1'b0);
            checkValue("t1_gnt", {31'b0, gnt}, 32'd0);
            checkValue("t1_rvalid", {31'b0, r_valid}, 32'd0);
            checkValue("t1_err", {31'b0, err}, 32'd0);
        end

        // Single read, response two cycles after the grant.
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 32'h0, 1'b1);
        checkValue("t2_gnt", {31'b0, gnt}, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1);
`ifdef SNAX_TCDM_RSP_BYPASS_EN
        checkValue("t2_rvalid_p", {31'b0, r_valid}, 32'd1);
        checkValue("t2_rdata_p", r_data, 32'hDEADBEEF);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        checkValue("t2_rvalid_n", {31'b0, r_valid}, 32'd0);
`else
        checkValue("t2_rvalid_p", {31'b0, r_valid}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        checkValue("t2_rvalid_n", {31'b0, r_valid}, 32'd1);
        checkValue("t2_rdata_n", r_data, 32'hDEADBEEF);
`endif
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        checkValue("t2_idle", {31'b0, r_valid}, 32'd0);

        // Six back-to-back reads with the streamer stalled: credits cap grants at four.
        grants = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 32'h300 + 32'(4 * i), 1'b1, 1'b0, 32'h0, 1'b0);
            if (gnt) grants++;
        end
        checkValue("t3_grants", 32'(grants), 32'd4);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 32'h1000 + 32'(i), 1'b0);
        end
        grants = 0;
        seen.delete();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, (grants < 2), 1'b1, 32'h400, 1'b1, 1'b0, 32'h0, 1'b1);
            if (gnt) grants++;
            if (r_valid) seen.push_back(r_data);
        end
        checkValue("t3_regrants", 32'(grants), 32'd2);
        checkValue("t3_nresp", 32'(seen.size()), 32'd4);
        for (int i = 0; i < seen.size(); i++) begin
            checkValue("t3_order", seen[i], 32'h1000 + 32'(i));
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 32'h2000 + 32'(i), 1'b1);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);

        // Interleaved W,R,W,R with a response every cycle: only the reads come back.
        seen.delete();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h200, 1'b1, 1'b0, 32'h0, 1'b1);
        if (r_valid) seen.push_back(r_data);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h204, 1'b1, 1'b1, 32'h0BAD0001, 1'b1);
        if (r_valid) seen.push_back(r_data);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h208, 1'b1, 1'b1, 32'hA1A1A1A1, 1'b1);
        if (r_valid) seen.push_back(r_data);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h20C, 1'b1, 1'b1, 32'h0BAD0002, 1'b1);
        if (r_valid) seen.push_back(r_data);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 32'hB2B2B2B2, 1'b1);
        if (r_valid) seen.push_back(r_data);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
            if (r_valid) seen.push_back(r_data);
        end
        checkValue("t4_nresp", 32'(seen.size()), 32'd2);
        if (seen.size() == 2) begin
            checkValue("t4_first", seen[0], 32'hA1A1A1A1);
            checkValue("t4_second", seen[1], 32'hB2B2B2B2);
        end

        // Memory not ready: no grant, and a stray response then proves no tag was queued.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 32'h500, 1'b0, 1'b0, 32'h0, 1'b1);
            checkValue("t5_gnt", {31'b0, gnt}, 32'd0);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 32'h55555555, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        checkValue("t5_err", {31'b0, err}, 32'd1);
        checkValue("t5_rvalid", {31'b0, r_valid}, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        checkValue("t5_err_clr", {31'b0, err}, 32'd0);

        // Reset with three reads in flight, then their late responses arrive.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 32'h600 + 32'(4 * i), 1'b1, 1'b0, 32'h0, 1'b1);
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        got = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 32'h6000 + 32'(i), 1'b1);
            if (i == 0) checkValue("t6_err_before", {31'b0, err}, 32'd0);
            if (r_valid) got++;
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        if (r_valid) got++;
        checkValue("t6_err", {31'b0, err}, 32'd1);
        checkValue("t6_no_rvalid", 32'(got), 32'd0);

        // Randomized traffic with an in-order memory, occasional mid-stream resets.
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        pending.delete();
        for (int i = 0; i < 3000; i++) begin
            pv = (pending.size() > 0) && ($urandom_range(0, 9) < 6);
            pd = pv ? pending[0] : 32'h0;
            applyStimulus(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) < 7),
                          1'($urandom), $urandom, ($urandom_range(0, 3) != 0),
                          pv, pd, ($urandom_range(0, 9) < 6));
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
